// File: rtl/ltc2387_tx.sv
// LTC2387 two-lane transmit emulator: serializes one 18-bit sample pair per frame,
// two bits per clock MSB first, with a 5-pulse DCO burst delayed by CO_DELAY cycles.
module ltc2387_tx #(
  parameter int CO_DELAY     = 1,
  parameter int FRAME_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        test_pattern,
  input  logic [17:0] sample0,
  input  logic [17:0] sample1,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        frame_start,
  output logic        din0_a,
  output logic        din0_b,
  output logic        din0_co,
  output logic        din1_a,
  output logic        din1_b,
  output logic        din1_co
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] SHIFT_LAST = 8'(9 + CO_DELAY);
  localparam logic [7:0] GAP_LAST   = 8'(FRAME_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [17:0] sh0_q;
  logic [17:0] sh1_q;
  logic [17:0] ramp_q;
  logic        ready_q;
  logic        start_q;
  logic        a0_q;
  logic        b0_q;
  logic        a1_q;
  logic        b1_q;
  logic        co_q;

  logic        accept;
  logic [17:0] src0;
  logic [17:0] src1;

  // cnt_q counts clock edges since the accepting edge.
  function automatic logic dco_at(input logic [7:0] k);
    int d;
    d = int'(k) - CO_DELAY;
    return (d >= 0) && (d <= 9) && ((d % 2) == 0);
  endfunction

  assign accept = ready_q && (test_pattern || sample_valid);
  assign src0   = test_pattern ? ramp_q  : sample0;
  assign src1   = test_pattern ? ~ramp_q : sample1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sh0_q   <= 18'd0;
      sh1_q   <= 18'd0;
      ramp_q  <= 18'd0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      a0_q    <= 1'b0;
      b0_q    <= 1'b0;
      a1_q    <= 1'b0;
      b1_q    <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          a0_q <= 1'b0;
          b0_q <= 1'b0;
          a1_q <= 1'b0;
          b1_q <= 1'b0;
          co_q <= 1'b0;
          start_q <= 1'b0;
          ready_q <= 1'b1;
          if (accept) begin
            // Pair 0 leaves on the accepting edge; the rest wait in the shift registers.
            a0_q    <= src0[17];
            b0_q    <= src0[16];
            a1_q    <= src1[17];
            b1_q    <= src1[16];
            sh0_q   <= src0 << 2;
            sh1_q   <= src1 << 2;
            co_q    <= dco_at(8'd0);
            start_q <= 1'b1;
            ready_q <= 1'b0;
            cnt_q   <= 8'd1;
            state_q <= SHIFT;
            if (test_pattern) begin
              ramp_q <= ramp_q + 18'd1;
            end
          end
        end
        SHIFT: begin
          start_q <= 1'b0;
          a0_q    <= sh0_q[17];
          b0_q    <= sh0_q[16];
          a1_q    <= sh1_q[17];
          b1_q    <= sh1_q[16];
          sh0_q   <= sh0_q << 2;
          sh1_q   <= sh1_q << 2;
          co_q    <= dco_at(cnt_q);
          cnt_q   <= cnt_q + 8'd1;
          if (cnt_q == SHIFT_LAST) begin
            state_q <= GAP;
          end
        end
        GAP: begin
          start_q <= 1'b0;
          a0_q    <= 1'b0;
          b0_q    <= 1'b0;
          a1_q    <= 1'b0;
          b1_q    <= 1'b0;
          co_q    <= 1'b0;
          cnt_q   <= cnt_q + 8'd1;
          if (cnt_q == GAP_LAST) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign frame_start  = start_q;
  assign din0_a       = a0_q;
  assign din0_b       = b0_q;
  assign din1_a       = a1_q;
  assign din1_b       = b1_q;
  assign din0_co      = co_q;
  assign din1_co      = co_q;

endmodule

// File: tb/tb_ltc2387_tx.sv
// Bench for ltc2387_tx: three builds (CO_DELAY 1/0/3) checked every cycle against a
// frame-timing model, plus table-driven and hand-written frame sequences on the default build.
module tb_ltc2387_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        test_pattern;
  logic        sample_valid;
  logic [17:0] sample0;
  logic [17:0] sample1;

  logic rdy[3], fs[3], a0[3], b0[3], co0[3], a1[3], b1[3], co1[3];

  ltc2387_tx #(.CO_DELAY(1), .FRAME_CYCLES(16)) u_d1 (
    .clk(clk), .resetn(resetn), .test_pattern(test_pattern), .sample0(sample0), .sample1(sample1),
    .sample_valid(sample_valid), .sample_ready(rdy[0]), .frame_start(fs[0]),
    .din0_a(a0[0]), .din0_b(b0[0]), .din0_co(co0[0]), .din1_a(a1[0]), .din1_b(b1[0]), .din1_co(co1[0]));

  ltc2387_tx #(.CO_DELAY(0), .FRAME_CYCLES(12)) u_d0 (
    .clk(clk), .resetn(resetn), .test_pattern(test_pattern), .sample0(sample0), .sample1(sample1),
    .sample_valid(sample_valid), .sample_ready(rdy[1]), .frame_start(fs[1]),
    .din0_a(a0[1]), .din0_b(b0[1]), .din0_co(co0[1]), .din1_a(a1[1]), .din1_b(b1[1]), .din1_co(co1[1]));

  ltc2387_tx #(.CO_DELAY(3), .FRAME_CYCLES(20)) u_d3 (
    .clk(clk), .resetn(resetn), .test_pattern(test_pattern), .sample0(sample0), .sample1(sample1),
    .sample_valid(sample_valid), .sample_ready(rdy[2]), .frame_start(fs[2]),
    .din0_a(a0[2]), .din0_b(b0[2]), .din0_co(co0[2]), .din1_a(a1[2]), .din1_b(b1[2]), .din1_co(co1[2]));

  typedef struct {
    logic [8:0] a0;
    logic [8:0] b0;
    logic [8:0] a1;
    logic [8:0] b1;
  } frame_t;

  typedef struct {
    logic [17:0] s0;
    logic [17:0] s1;
    logic [8:0]  a0;
    logic [8:0]  b0;
    logic [8:0]  a1;
    logic [8:0]  b1;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: edges since the accepting edge (-1 = no frame running)
  int          co_p[3];
  int          fc_p[3];
  int          since[3];
  logic        exp_rdy[3];
  logic [17:0] m0[3];
  logic [17:0] m1[3];
  logic [17:0] ramp[3];

  // Frame reconstruction on the default build
  int     rec_j = -1;
  frame_t rec_f;
  frame_t exp_q[$];
  int     frames_done = 0;
  int     fs_times[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic frame_t mkframe(input logic [17:0] v0, input logic [17:0] v1);
    frame_t f;
    for (int i = 0; i < 9; i++) begin
      f.a0[8-i] = v0[17-2*i];
      f.b0[8-i] = v0[16-2*i];
      f.a1[8-i] = v1[17-2*i];
      f.b1[8-i] = v1[16-2*i];
    end
    return f;
  endfunction

  // One clock: advance to just after the edge, update the model with the inputs seen there, compare.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] expv;
      logic [7:0] actv;
      int j;
      int d;
      logic dco;
      expv = 8'd0;
      if (!resetn) begin
        since[k]   = -1;
        exp_rdy[k] = 1'b0;
        ramp[k]    = 18'd0;
      end else begin
        if (exp_rdy[k] && (test_pattern || sample_valid)) begin
          since[k] = 0;
          if (test_pattern) begin
            m0[k]   = ramp[k];
            m1[k]   = ~ramp[k];
            ramp[k] = ramp[k] + 18'd1;
          end else begin
            m0[k] = sample0;
            m1[k] = sample1;
          end
        end else if (since[k] >= 0) begin
          since[k]++;
        end
        j = since[k];
        if (since[k] >= fc_p[k] - 1) since[k] = -1;
        exp_rdy[k] = (since[k] < 0);
        expv[7] = exp_rdy[k];
        expv[6] = (j == 0);
        if (j >= 0 && j <= 8) begin
          expv[5] = m0[k][17-2*j];
          expv[4] = m0[k][16-2*j];
          expv[3] = m1[k][17-2*j];
          expv[2] = m1[k][16-2*j];
        end
        d = j - co_p[k];
        dco = (j >= 0) && (d >= 0) && (d <= 9) && ((d % 2) == 0);
        expv[1] = dco;
        expv[0] = dco;
      end
      actv = {rdy[k], fs[k], a0[k], b0[k], a1[k], b1[k], co0[k], co1[k]};
      check($sformatf("outputs[co=%0d]", co_p[k]), 32'(actv), 32'(expv));
    end

    if (fs[0] === 1'b1) fs_times.push_back(cyc);
    if (!resetn) begin
      rec_j = -1;
    end else begin
      if (fs[0] === 1'b1) rec_j = 0;
      if (rec_j >= 0 && rec_j <= 8) begin
        rec_f.a0[8-rec_j] = a0[0];
        rec_f.b0[8-rec_j] = b0[0];
        rec_f.a1[8-rec_j] = a1[0];
        rec_f.b1[8-rec_j] = b1[0];
        if (rec_j == 8) begin
          frames_done++;
          if (exp_q.size() > 0) begin
            frame_t e;
            e = exp_q.pop_front();
            check("frame din0_a", 32'(rec_f.a0), 32'(e.a0));
            check("frame din0_b", 32'(rec_f.b0), 32'(e.b0));
            check("frame din1_a", 32'(rec_f.a1), 32'(e.a1));
            check("frame din1_b", 32'(rec_f.b1), 32'(e.b1));
          end
          rec_j = -1;
        end else begin
          rec_j++;
        end
      end
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!exp_rdy[0] && n < 100) begin
      step();
      n++;
    end
    check("wait_ready bound", 32'(exp_rdy[0]), 32'd1);
  endtask

  vec_t tbl[5];

  initial begin
    co_p[0] = 1; fc_p[0] = 16;
    co_p[1] = 0; fc_p[1] = 12;
    co_p[2] = 3; fc_p[2] = 20;
    for (int k = 0; k < 3; k++) begin
      since[k] = -1; exp_rdy[k] = 1'b0; m0[k] = '0; m1[k] = '0; ramp[k] = '0;
    end
    tbl[0] = '{18'h20001, 18'h00000, 9'h100, 9'h001, 9'h000, 9'h000};
    tbl[1] = '{18'h2AAAA, 18'h15555, 9'h1FF, 9'h000, 9'h000, 9'h1FF};
    tbl[2] = '{18'h3FFFF, 18'h00000, 9'h1FF, 9'h1FF, 9'h000, 9'h000};
    tbl[3] = '{18'h0F0F0, 18'h3FFFF, 9'h0CC, 9'h0CC, 9'h1FF, 9'h1FF};
    tbl[4] = '{18'h00000, 18'h20001, 9'h000, 9'h000, 9'h100, 9'h001};

    resetn = 1'b0; test_pattern = 1'b0; sample_valid = 1'b0;
    sample0 = '0; sample1 = '0;
    repeat (3) step();
    resetn = 1'b1;
    step();
    check("ready after release", 32'(rdy[0]), 32'd1);

    // Table-driven frames; samples scrambled after accept must not leak into the frame
    for (int t = 0; t < 5; t++) begin
      wait_ready();
      exp_q.push_back('{tbl[t].a0, tbl[t].b0, tbl[t].a1, tbl[t].b1});
      sample_valid = 1'b1; sample0 = tbl[t].s0; sample1 = tbl[t].s1;
      step();
      sample_valid = 1'b0; sample0 = 18'($urandom); sample1 = 18'($urandom);
      repeat (12) step();
    end
    check("table frames drained", 32'(exp_q.size()), 32'd0);

    // sample_valid held high: accepts exactly FRAME_CYCLES apart
    wait_ready();
    fs_times.delete();
    sample_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sample0 = 18'($urandom); sample1 = 18'($urandom);
      step();
    end
    sample_valid = 1'b0;
    check("held-valid accepts", 32'(fs_times.size()), 32'd3);
    if (fs_times.size() == 3) begin
      check("accept spacing 1", 32'(fs_times[1] - fs_times[0]), 32'd16);
      check("accept spacing 2", 32'(fs_times[2] - fs_times[1]), 32'd16);
    end
    repeat (20) step();

    // Test pattern from reset: ramp 0..3 on ch0, complement on ch1
    resetn = 1'b0;
    repeat (2) step();
    test_pattern = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(mkframe(18'(i), ~18'(i)));
    frames_done = 0;
    resetn = 1'b1;
    for (int n = 0; n < 200 && frames_done < 4; n++) step();
    test_pattern = 1'b0;
    check("pattern frames seen", 32'(frames_done), 32'd4);
    check("pattern frames drained", 32'(exp_q.size()), 32'd0);
    repeat (20) step();

    // Reset sampled at A+5 aborts the frame; next frame after release is clean
    wait_ready();
    sample_valid = 1'b1; sample0 = 18'h3FFFF; sample1 = 18'h3FFFF;
    step();
    sample_valid = 1'b0;
    repeat (4) step();
    resetn = 1'b0;
    step();
    check("abort lanes zero", 32'({a0[0], b0[0], a1[0], b1[0], co0[0], co1[0]}), 32'd0);
    resetn = 1'b1;
    step();
    check("ready after abort release", 32'(rdy[0]), 32'd1);
    exp_q.push_back(mkframe(18'h12345, 18'h2BCDE));
    sample_valid = 1'b1; sample0 = 18'h12345; sample1 = 18'h2BCDE;
    step();
    sample_valid = 1'b0;
    repeat (20) step();
    check("post-abort frame drained", 32'(exp_q.size()), 32'd0);

    // Randomized traffic, all three builds checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample0      = 18'($urandom);
      sample1      = 18'($urandom);
      test_pattern = ($urandom_range(0, 15) == 0);
      resetn       = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
